// File: rtl/bp_be_stride_prefetch_gen.sv
// ---------------------------------------------------------------------------
// bp_be_stride_prefetch_gen
//
// Turns stride-detector discovery events into line-aligned prefetch requests
// for the D$ prefetch port. A trigger loads a burst that walks
// base + k*stride for k = 1..N. N is degree_p for a confirm pulse and 1 for a
// start pulse. Candidates that leave the 4 KiB page of the base end the burst.
// Candidates whose line is in a small FIFO of recently issued lines are
// skipped, one cycle each.
//
// Handshake: pf_v_o / pf_addr_o are registered. Once pf_v_o is raised, it and
// pf_addr_o hold unchanged until the cycle where pf_v_o & pf_ready_and_i. That
// cycle is the transfer.
//
// Ports
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   start_discovery_i       pulse: first stride seen (burst of 1)
//   confirm_discovery_i     pulse: stride confirmed (burst of degree_p), wins
//   base_addr_i             effective address of the triggering access
//   stride_i                signed stride, valid with either pulse
//   flush_i                 drop pending trigger and rest of the burst
//   pf_v_o, pf_addr_o       prefetch request (line aligned)
//   pf_ready_and_i          D$ accepts the request
//   busy_o                  FSM in e_issue (doubles as the FSM state view)
// ---------------------------------------------------------------------------
module bp_be_stride_prefetch_gen
  #(parameter int vaddr_width_p       = 39
  , parameter int stride_width_p      = 8
  , parameter int degree_p            = 4
  , parameter int filter_els_p        = 4
  , parameter int block_width_p       = 512
  , parameter int page_offset_width_p = 12
  )
  (input  logic                      clk_i
  , input  logic                      reset_n_i
  , input  logic                      start_discovery_i
  , input  logic                      confirm_discovery_i
  , input  logic [vaddr_width_p-1:0]  base_addr_i
  , input  logic [stride_width_p-1:0] stride_i
  , input  logic                      flush_i
  , output logic                      pf_v_o
  , output logic [vaddr_width_p-1:0]  pf_addr_o
  , input  logic                      pf_ready_and_i
  , output logic                      busy_o
  );

  localparam int line_offset_lp = $clog2(block_width_p/8);
  localparam int line_width_lp  = vaddr_width_p - line_offset_lp;
  localparam int page_width_lp  = vaddr_width_p - page_offset_width_p;
  localparam int cnt_width_lp   = $clog2(degree_p+1);
  localparam int ptr_width_lp   = (filter_els_p > 1) ? $clog2(filter_els_p) : 1;

  typedef enum logic {e_idle, e_issue} state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e                     state_q, state_d;
  logic [page_width_lp-1:0]   base_page_q, base_page_d;
  logic [vaddr_width_p-1:0]   stride_q, stride_d;
  logic [vaddr_width_p-1:0]   cand_q, cand_d;
  logic [cnt_width_lp-1:0]    cnt_q, cnt_d;

  logic                       pend_v_q, pend_v_d;
  logic [vaddr_width_p-1:0]   pend_base_q, pend_base_d;
  logic [stride_width_p-1:0]  pend_stride_q, pend_stride_d;
  logic                       pend_conf_q, pend_conf_d;

  logic                       pf_v_q, pf_v_d;
  logic [vaddr_width_p-1:0]   pf_addr_q, pf_addr_d;

  logic [line_width_lp-1:0]   filt_line_q [filter_els_p];
  logic [line_width_lp-1:0]   filt_line_d [filter_els_p];
  logic [filter_els_p-1:0]    filt_v_q, filt_v_d;
  logic [ptr_width_lp-1:0]    filt_ptr_q, filt_ptr_d;

  // -------------------------------------------------------------------------
  // Trigger selection
  // -------------------------------------------------------------------------
  logic                       hs;
  logic                       trig_v;
  logic                       fresh_v;
  logic [vaddr_width_p-1:0]   fresh_base;
  logic [stride_width_p-1:0]  fresh_stride;
  logic                       fresh_conf;
  logic [vaddr_width_p-1:0]   fresh_stride_ext;
  logic [vaddr_width_p-1:0]   cand_adv;
  logic                       cross_now;
  logic [cnt_width_lp-1:0]    cnt_dec;
  logic                       load_fresh;
  logic                       advance;
  logic                       cand_hit;
  logic                       cand_cross;
  logic                       issue_ok;

  assign hs     = pf_v_q & pf_ready_and_i;
  // A zero stride would re-request the triggering line forever; drop it.
  assign trig_v = (start_discovery_i | confirm_discovery_i) & (stride_i != '0);

  // A trigger arriving this cycle is newer than anything held in pending.
  assign fresh_v      = trig_v | pend_v_q;
  assign fresh_base   = trig_v ? base_addr_i         : pend_base_q;
  assign fresh_stride = trig_v ? stride_i            : pend_stride_q;
  assign fresh_conf   = trig_v ? confirm_discovery_i : pend_conf_q;
  assign fresh_stride_ext =
    {{(vaddr_width_p-stride_width_p){fresh_stride[stride_width_p-1]}}, fresh_stride};

  assign cand_adv  = cand_q + stride_q;
  // Re-derived from registers; only consulted when the candidate was not
  // presented, to tell a page-cross stop from a filter skip.
  assign cross_now = (cand_q[vaddr_width_p-1:page_offset_width_p] != base_page_q);
  // cnt_q is 0 after a flush that left a request on the bus; saturate so
  // the following handshake still ends the burst.
  assign cnt_dec   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    base_page_d   = base_page_q;
    stride_d      = stride_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    pend_v_d      = pend_v_q;
    pend_base_d   = pend_base_q;
    pend_stride_d = pend_stride_q;
    pend_conf_d   = pend_conf_q;
    load_fresh    = 1'b0;
    advance       = 1'b0;

    unique case (state_q)
      e_idle: begin
        if (trig_v & ~flush_i) load_fresh = 1'b1;
      end
      e_issue: begin
        if (flush_i) begin
          // A presented request still completes; everything else is dropped.
          pend_v_d = 1'b0;
          cnt_d    = '0;
          if (~pf_v_q | pf_ready_and_i) state_d = e_idle;
        end else begin
          if (trig_v) begin
            pend_v_d      = 1'b1;
            pend_base_d   = base_addr_i;
            pend_stride_d = stride_i;
            pend_conf_d   = confirm_discovery_i;
          end
          if (pf_v_q & ~pf_ready_and_i) begin
            // stalled: hold everything
          end else if ((~pf_v_q & cross_now) | (cnt_dec == '0)) begin
            // Burst over; chain straight into a waiting trigger if any.
            if (fresh_v) begin
              load_fresh = 1'b1;
            end else begin
              state_d = e_idle;
              cnt_d   = '0;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = e_idle;
    endcase

    if (load_fresh) begin
      state_d     = e_issue;
      base_page_d = fresh_base[vaddr_width_p-1:page_offset_width_p];
      stride_d    = fresh_stride_ext;
      cand_d      = fresh_base + fresh_stride_ext;
      cnt_d       = fresh_conf ? cnt_width_lp'(degree_p) : cnt_width_lp'(1);
      pend_v_d    = 1'b0;
    end else if (advance) begin
      cand_d = cand_adv;
      cnt_d  = cnt_dec;
    end
  end

  // -------------------------------------------------------------------------
  // Recently-issued filter, FIFO replacement
  // -------------------------------------------------------------------------
  always_comb begin
    filt_line_d = filt_line_q;
    filt_v_d    = filt_v_q;
    filt_ptr_d  = filt_ptr_q;
    if (hs) begin
      filt_line_d[filt_ptr_q] = pf_addr_q[vaddr_width_p-1:line_offset_lp];
      filt_v_d[filt_ptr_q]    = 1'b1;
      filt_ptr_d = (filt_ptr_q == ptr_width_lp'(filter_els_p-1))
                   ? '0 : filt_ptr_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Classify the next candidate so pf_v_o can be registered. The lookup uses
  // the post-insert filter so a line handed over this cycle already counts.
  // -------------------------------------------------------------------------
  always_comb begin
    cand_hit = 1'b0;
    for (int i = 0; i < filter_els_p; i++) begin
      if (filt_v_d[i] && (filt_line_d[i] == cand_d[vaddr_width_p-1:line_offset_lp]))
        cand_hit = 1'b1;
    end
  end

  assign cand_cross = (cand_d[vaddr_width_p-1:page_offset_width_p] != base_page_d);
  assign issue_ok   = (load_fresh | advance) & ~cand_cross & ~cand_hit;

  always_comb begin
    pf_v_d    = (load_fresh | advance) ? issue_ok : (pf_v_q & ~hs);
    pf_addr_d = pf_addr_q;
    if (issue_ok)
      pf_addr_d = {cand_d[vaddr_width_p-1:line_offset_lp], {line_offset_lp{1'b0}}};
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= e_idle;
      base_page_q   <= '0;
      stride_q      <= '0;
      cand_q        <= '0;
      cnt_q         <= '0;
      pend_v_q      <= 1'b0;
      pend_base_q   <= '0;
      pend_stride_q <= '0;
      pend_conf_q   <= 1'b0;
      pf_v_q        <= 1'b0;
      pf_addr_q     <= '0;
      filt_v_q      <= '0;
      filt_ptr_q    <= '0;
      for (int i = 0; i < filter_els_p; i++) filt_line_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      base_page_q   <= base_page_d;
      stride_q      <= stride_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      pend_v_q      <= pend_v_d;
      pend_base_q   <= pend_base_d;
      pend_stride_q <= pend_stride_d;
      pend_conf_q   <= pend_conf_d;
      pf_v_q        <= pf_v_d;
      pf_addr_q     <= pf_addr_d;
      filt_v_q      <= filt_v_d;
      filt_ptr_q    <= filt_ptr_d;
      for (int i = 0; i < filter_els_p; i++) filt_line_q[i] <= filt_line_d[i];
    end
  end

  assign pf_v_o    = pf_v_q;
  assign pf_addr_o = pf_addr_q;
  assign busy_o    = (state_q == e_issue);

endmodule

// File: tb/tb_bp_be_stride_prefetch_gen.sv
// ---------------------------------------------------------------------------
// tb_bp_be_stride_prefetch_gen
//
// Directed vector table (one trigger per row, six sampled cycles each), a set
// of hand-written multi-cycle sequences (stall, pending overwrite, flush,
// asynchronous reset), then random triggers with random ready checked
// against a burst-walking reference model.
// ---------------------------------------------------------------------------
module tb_bp_be_stride_prefetch_gen;
  localparam int W = 39;

  // ---------------------------------------------------------------- clock/reset
  logic         clk = 1'b0;
  logic         reset_n;
  logic         start_disc;
  logic         confirm_disc;
  logic [W-1:0] base_addr;
  logic [7:0]   stride;
  logic         flush;
  logic         pf_v;
  logic [W-1:0] pf_addr;
  logic         pf_ready;
  logic         busy;

  always #5 clk = ~clk;

  bp_be_stride_prefetch_gen #(
    .vaddr_width_p(W), .stride_width_p(8), .degree_p(4), .filter_els_p(4),
    .block_width_p(512), .page_offset_width_p(12)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .start_discovery_i(start_disc), .confirm_discovery_i(confirm_disc),
    .base_addr_i(base_addr), .stride_i(stride), .flush_i(flush),
    .pf_v_o(pf_v), .pf_addr_o(pf_addr), .pf_ready_and_i(pf_ready),
    .busy_o(busy)
  );

  // ---------------------------------------------------------------- scoreboard
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-7:0] filt_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input string name, input logic v, input logic [W-1:0] a,
                            input logic b);
    chk({name, "_busy"}, busy, b);
    chk({name, "_v"}, pf_v, v);
    if (v) chk({name, "_addr"}, pf_addr, a);
  endtask

  task automatic drive_trig(input logic st, input logic cf, input logic [W-1:0] b,
                            input logic [7:0] s);
    start_disc   = st;
    confirm_disc = cf;
    base_addr    = b;
    stride       = s;
    tick();
    start_disc   = 1'b0;
    confirm_disc = 1'b0;
  endtask

  // Reference: walk base + k*stride, stop at a page change, drop lines in
  // the 4-deep FIFO of recent lines, record everything else in issue order.
  function automatic void model_trigger(input logic [W-1:0] b, input logic [7:0] s,
                                        input bit conf);
    logic [W-1:0] step;
    logic [W-1:0] c;
    logic [W-7:0] line;
    bit seen;
    int n;
    if (s == 8'h00) return;
    step = {{(W-8){s[7]}}, s};
    n = conf ? 4 : 1;
    c = b;
    for (int k = 0; k < n; k++) begin
      c = c + step;
      if (c[W-1:12] != b[W-1:12]) break;
      line = c[W-1:6];
      seen = 0;
      foreach (filt_q[i]) if (filt_q[i] == line) seen = 1;
      if (!seen) begin
        exp_q.push_back({line, 6'b0});
        filt_q.push_back(line);
        if (filt_q.size() > 4) void'(filt_q.pop_front());
      end
    end
  endfunction

  // ---------------------------------------------------------------- vector table
  typedef struct {
    logic            st;
    logic            cf;
    logic [W-1:0]    base;
    logic [7:0]      stride;
    int              busy_len;
    logic [5:0]      v_mask;
    logic [3:0][W-1:0] addr;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mkv(input logic st, input logic cf, input logic [W-1:0] b,
                               input logic [7:0] s, input int bl, input logic [5:0] vm,
                               input logic [W-1:0] a0, input logic [W-1:0] a1,
                               input logic [W-1:0] a2, input logic [W-1:0] a3);
    vec_t v;
    v.st = st; v.cf = cf; v.base = b; v.stride = s; v.busy_len = bl; v.v_mask = vm;
    v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2; v.addr[3] = a3;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    pf_ready = 1'b1;
    drive_trig(v.st, v.cf, v.base, v.stride);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("v%0d_busy_c%0d", idx, k), busy, (k < v.busy_len));
      chk($sformatf("v%0d_v_c%0d", idx, k), pf_v, v.v_mask[k]);
      if (v.v_mask[k] && k < 4)
        chk($sformatf("v%0d_addr_c%0d", idx, k), pf_addr, v.addr[k]);
      tick();
    end
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------- test body
  initial begin
    logic [W-1:0] rb;
    logic [7:0]   rs;
    int           kind;
    bit           stall_prev;
    logic [W-1:0] prev_addr;

    reset_n = 1'b1; start_disc = 0; confirm_disc = 0; base_addr = '0;
    stride = '0; flush = 0; pf_ready = 1'b1;

    vecs[0]  = mkv(0, 1, 'h1000, 8'h40, 4, 6'b001111, 'h1040, 'h1080, 'h10C0, 'h1100);
    vecs[1]  = mkv(0, 1, 'h1000, 8'h40, 4, 6'b000000, 0, 0, 0, 0);
    vecs[2]  = mkv(0, 1, 'h3000, 8'h08, 4, 6'b000001, 'h3000, 0, 0, 0);
    vecs[3]  = mkv(1, 0, 'h2000, 8'h40, 1, 6'b000001, 'h2040, 0, 0, 0);
    vecs[4]  = mkv(0, 1, 'h3000, 8'hF8, 1, 6'b000000, 0, 0, 0, 0);
    vecs[5]  = mkv(0, 1, 'h0FC0, 8'h40, 1, 6'b000000, 0, 0, 0, 0);
    vecs[6]  = mkv(0, 1, 'h5000, 8'h00, 0, 6'b000000, 0, 0, 0, 0);
    vecs[7]  = mkv(1, 1, 'h7000, 8'h7F, 4, 6'b001111, 'h7040, 'h70C0, 'h7140, 'h71C0);
    vecs[8]  = mkv(0, 1, 'h3100, 8'hC0, 4, 6'b001111, 'h30C0, 'h3080, 'h3040, 'h3000);
    vecs[9]  = mkv(0, 1, 'h0F80, 8'h40, 2, 6'b000001, 'h0FC0, 0, 0, 0);
    vecs[10] = mkv(0, 1, 39'h7F_FFFF_FFC0, 8'h40, 1, 6'b000000, 0, 0, 0, 0);

    // Reset values, reset asserted without waiting for a clock edge
    #1 reset_n = 1'b0;
    #1;
    chk("rst_pf_v", pf_v, 1'b0);
    chk("rst_pf_addr", pf_addr, '0);
    chk("rst_busy", busy, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1'b0);

    // Directed table
    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Stall: first request held four cycles, then back-to-back
    pf_ready = 1'b0;
    drive_trig(0, 1, 'h9000, 8'h40);
    for (int k = 0; k < 3; k++) begin
      expect_cyc("stall_hold", 1, 'h9040, 1);
      tick();
    end
    pf_ready = 1'b1;
    expect_cyc("stall_hs", 1, 'h9040, 1); tick();
    expect_cyc("stall_1", 1, 'h9080, 1); tick();
    expect_cyc("stall_2", 1, 'h90C0, 1); tick();
    expect_cyc("stall_3", 1, 'h9100, 1); tick();
    expect_cyc("stall_end", 0, '0, 0);

    // Pending overwrite: start 0x5800 replaced by confirm 0x6000
    pf_ready = 1'b0;
    drive_trig(1, 0, 'h5000, 8'h40);
    expect_cyc("pend_a", 1, 'h5040, 1);
    drive_trig(1, 0, 'h5800, 8'h40);
    expect_cyc("pend_b", 1, 'h5040, 1);
    drive_trig(0, 1, 'h6000, 8'h40);
    expect_cyc("pend_c", 1, 'h5040, 1);
    pf_ready = 1'b1;
    tick();
    expect_cyc("pend_0", 1, 'h6040, 1); tick();
    expect_cyc("pend_1", 1, 'h6080, 1); tick();
    expect_cyc("pend_2", 1, 'h60C0, 1); tick();
    expect_cyc("pend_3", 1, 'h6100, 1); tick();
    expect_cyc("pend_end", 0, '0, 0);

    // Flush with a request on the bus: it completes, nothing follows
    pf_ready = 1'b0;
    drive_trig(0, 1, 'hA000, 8'h40);
    expect_cyc("fl_a", 1, 'hA040, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_cyc("fl_b", 1, 'hA040, 1);
    pf_ready = 1'b1;
    tick();
    expect_cyc("fl_c", 0, '0, 0);
    tick();
    expect_cyc("fl_d", 0, '0, 0);

    // Flush during a filter skip: idle next cycle (0x6080 is still filtered)
    drive_trig(0, 1, 'h6040, 8'h40);
    expect_cyc("fl_skip_a", 0, '0, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_cyc("fl_skip_b", 0, '0, 0);

    // Flush and trigger together: trigger dropped
    flush = 1'b1;
    drive_trig(0, 1, 'hC000, 8'h40);
    flush = 1'b0;
    expect_cyc("fl_trig", 0, '0, 0);

    // Asynchronous reset mid-burst, then filter found empty
    pf_ready = 1'b1;
    drive_trig(0, 1, 'hB000, 8'h40);
    expect_cyc("ar_a", 1, 'hB040, 1);
    tick();
    expect_cyc("ar_b", 1, 'hB080, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("ar_pf_v", pf_v, 1'b0);
    chk("ar_busy", busy, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    run_vec(100, vecs[0]);

    // Random triggers against the reference model, starting from empty filter
    do_reset();
    exp_q.delete();
    filt_q.delete();
    for (int t = 0; t < 80; t++) begin
      rb = W'(39'h4000 + ($urandom_range(0, 2) << 12) + $urandom_range(0, 4095));
      rs = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 2);
      model_trigger(rb, rs, kind != 0);
      drive_trig(kind != 1, kind != 0, rb, rs);
      chk("rnd_busy_start", busy, (rs != 8'h00));
      stall_prev = 0;
      prev_addr  = '0;
      for (int c = 0; c < 60 && busy; c++) begin
        pf_ready = ($urandom_range(0, 3) != 0);
        if (stall_prev) begin
          chk("rnd_hold_v", pf_v, 1'b1);
          chk("rnd_hold_addr", pf_addr, prev_addr);
        end
        if (pf_v && pf_ready) begin
          if (exp_q.size() == 0) chk("rnd_extra_req", pf_addr, '1);
          else chk("rnd_addr", pf_addr, exp_q.pop_front());
        end
        stall_prev = pf_v && !pf_ready;
        prev_addr  = pf_addr;
        tick();
      end
      chk("rnd_timeout", busy, 1'b0);
      chk("rnd_left", exp_q.size(), 0);
      exp_q.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
